// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetch FSM with jump/branch
// predecode, a 2-bit saturating branch history table and a single pending
// redirect target that follows the branch delay slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          BHT_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] REDIRECT_PC,
  input  logic        BR_UPDATE,
  input  logic [31:0] BR_UPDATE_PC,
  input  logic        BR_UPDATE_TAKEN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_VALID,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] Instr1_IF,
  output logic [31:0] Instr_PC_IF,
  output logic [31:0] Instr_PC_Plus4_IF,
  output logic        Branch_prediction_OUT,
  output logic        Instr_valid_OUT
);

  localparam int BHT_SIZE = 1 << BHT_BITS;

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD, ST_DROP} state_t;

  state_t              state, next_state;
  logic [31:0]         pc;
  logic [31:0]         pend_target;
  logic                pend_valid;
  logic [1:0]          bht [BHT_SIZE];

  logic [5:0]          opcode;
  logic [31:0]         pc_plus4, br_target, jmp_target;
  logic                is_cond, is_jump, pred_taken, accept;
  logic [BHT_BITS-1:0] lookup_idx, update_idx;
  logic                unused_update_bits;

  // Predecode of the returning instruction; lookup reads the table before
  // any same-cycle update lands, so it always sees the pre-update counter.
  assign opcode     = IMEM_DATA[31:26];
  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + {{14{IMEM_DATA[15]}}, IMEM_DATA[15:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], IMEM_DATA[25:0], 2'b00};
  assign is_cond    = opcode inside {6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001};
  assign is_jump    = opcode inside {6'b000010, 6'b000011};
  assign lookup_idx = pc[BHT_BITS+1:2];
  assign update_idx = BR_UPDATE_PC[BHT_BITS+1:2];

  // The delay slot of a predicted-taken branch is never itself predicted:
  // its successor is already fixed by the pending target.
  assign pred_taken = !pend_valid && (is_jump || (is_cond && (bht[lookup_idx] >= 2'd2)));

  // A response is only consumed in WAIT and only if no redirect is arriving.
  assign accept = (state == ST_WAIT) && IMEM_VALID && !FLUSH;

  assign unused_update_bits = ^{BR_UPDATE_PC[31:BHT_BITS+2], BR_UPDATE_PC[1:0]};

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!RESET) state <= ST_FETCH;
    else        state <= next_state;
  end

  // Next-state and memory-request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    next_state = state;
    IMEM_REQ   = 1'b0;
    IMEM_ADDR  = 32'h0;
    case (state)
      ST_FETCH: begin
        // A redirect in the request cycle cancels the request outright, so
        // no orphaned response can ever be in flight.
        if (!FLUSH && RESET) begin
          IMEM_REQ   = 1'b1;
          IMEM_ADDR  = {pc[31:2], 2'b00};
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (FLUSH)           next_state = IMEM_VALID ? ST_FETCH : ST_DROP;
        else if (IMEM_VALID) next_state = STALL ? ST_HOLD : ST_FETCH;
      end
      ST_HOLD: begin
        if (FLUSH || !STALL) next_state = ST_FETCH;
      end
      ST_DROP: begin
        if (IMEM_VALID) next_state = ST_FETCH;
      end
      default: next_state = ST_FETCH;
    endcase
  end

  // Fetch PC and pending predicted target.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc          <= RESET_PC;
      pend_target <= 32'h0;
      pend_valid  <= 1'b0;
    end else if (FLUSH) begin
      pc         <= REDIRECT_PC;
      pend_valid <= 1'b0;
    end else if (accept) begin
      if (pend_valid) begin
        pc         <= pend_target;
        pend_valid <= 1'b0;
      end else begin
        pc <= pc_plus4;
        if (pred_taken) begin
          pend_target <= is_jump ? jmp_target : br_target;
          pend_valid  <= 1'b1;
        end
      end
    end
  end

  // IF/ID outputs: load on an accepted response, freeze in HOLD while
  // stalled, otherwise present a bubble with the last PC kept.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr1_IF             <= 32'h0;
      Instr_PC_IF           <= 32'h0;
      Instr_PC_Plus4_IF     <= 32'h0;
      Branch_prediction_OUT <= 1'b0;
      Instr_valid_OUT       <= 1'b0;
    end else if (accept) begin
      Instr1_IF             <= IMEM_DATA;
      Instr_PC_IF           <= pc;
      Instr_PC_Plus4_IF     <= pc_plus4;
      Branch_prediction_OUT <= pred_taken;
      Instr_valid_OUT       <= 1'b1;
    end else if (FLUSH || !(state == ST_HOLD && STALL)) begin
      Instr1_IF             <= 32'h0;
      Branch_prediction_OUT <= 1'b0;
      Instr_valid_OUT       <= 1'b0;
    end
  end

  // Branch history table: 2-bit saturating counters, trained independently
  // of stall and flush.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: this array is reset because every counter must start weakly
      // not-taken; storage arrays without that need are left unreset.
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (BR_UPDATE) begin
      if (BR_UPDATE_TAKEN) begin
        if (bht[update_idx] != 2'b11) bht[update_idx] <= bht[update_idx] + 2'b01;
      end else begin
        if (bht[update_idx] != 2'b00) bht[update_idx] <= bht[update_idx] - 2'b01;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning first fetch address after reset.
REQ-002 SHALL have parameter BHT_BITS, default 4, meaning log2 of branch-history-table entries (16).
REQ-003 SHALL have port CLK  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port STALL  in  1  downstream IF/ID latch frozen; hold outputs.
REQ-006 SHALL have port FLUSH  in  1  redirect request from later stage.
REQ-007 SHALL have port REDIRECT_PC  in  32  new fetch address, sampled when FLUSH=1.
REQ-008 SHALL have port BR_UPDATE  in  1  resolved conditional branch strobe.
REQ-009 SHALL have port BR_UPDATE_PC  in  32  address of the resolved branch.
REQ-010 SHALL have port BR_UPDATE_TAKEN  in  1  resolved direction.
REQ-011 SHALL have port IMEM_REQ  out  1  instruction-memory request, one-cycle pulse.
REQ-012 SHALL have port IMEM_ADDR  out  32  request address, word-aligned.
REQ-013 SHALL have port IMEM_VALID  in  1  response strobe, arrives 1..N cycles after IMEM_REQ.
REQ-014 SHALL have port IMEM_DATA  in  32  response instruction, valid with IMEM_VALID.
REQ-015 SHALL have port Instr1_IF  out  32  fetched instruction to IF/ID latch.
REQ-016 SHALL have port Instr_PC_IF  out  32  address of Instr1_IF.
REQ-017 SHALL have port Instr_PC_Plus4_IF  out  32  Instr_PC_IF+4.
REQ-018 SHALL have port Branch_prediction_OUT  out  1  1 = Instr1_IF predicted taken.
REQ-019 SHALL have port Instr_valid_OUT  out  1  outputs carry a real instruction.

Function
REQ-020 SHALL run FSM states FETCH, WAIT, HOLD, DROP; at most one IMEM request outstanding.
REQ-021 FETCH: SHALL assert IMEM_REQ=1, IMEM_ADDR=PC for exactly one cycle, then go to WAIT.
REQ-022 WAIT: on IMEM_VALID SHALL register IMEM_DATA, PC, PC+4 and prediction onto outputs with Instr_valid_OUT=1, compute next PC, then go to HOLD if STALL=1, else FETCH.
REQ-023 HOLD: SHALL keep all outputs and PC unchanged while STALL=1; on STALL=0 go to FETCH.
REQ-024 In FETCH/WAIT with no new response, Instr_valid_OUT SHALL be 0 and Instr1_IF SHALL be 0 (nop); PC outputs keep last value.
REQ-025 Predecode: opcode 000100/000101/000110/000111/000001 = conditional branch; target = PC+4 + (sign-extended imm16 << 2), 32-bit wrap.
REQ-026 Opcode 000010/000011 = jump; target = {PC+4[31:28], instr[25:0], 2'b00}; always predicted taken.
REQ-027 Conditional branch predicted taken iff BHT[PC[BHT_BITS+1:2]] >= 2.
REQ-028 Predicted-taken SHALL set Branch_prediction_OUT=1 on that instruction, fetch PC+4 (delay slot) next, then the stored target; the pending-target register SHALL clear once used.
REQ-029 Otherwise next PC SHALL be PC+4, wrapping 32'hFFFFFFFC -> 0.
REQ-030 BHT: 2-bit saturating counters; BR_UPDATE increments (sat. 3) if TAKEN else decrements (sat. 0), index BR_UPDATE_PC[BHT_BITS+1:2].
REQ-031 Same-cycle lookup and update of one entry: lookup SHALL use the pre-update value.
REQ-032 FLUSH SHALL override STALL and any prediction: PC <= REDIRECT_PC, pending target cleared, Instr_valid_OUT=0, Instr1_IF=0, Branch_prediction_OUT=0 next cycle.
REQ-033 FLUSH in FETCH/HOLD SHALL go to FETCH; FLUSH in WAIT SHALL go to DROP (same-cycle IMEM_VALID counts as dropped, go to FETCH).
REQ-034 DROP: SHALL discard the next IMEM_VALID response, then go to FETCH at the redirect PC; a further FLUSH in DROP SHALL update the redirect PC.
REQ-035 BHT update SHALL proceed regardless of STALL/FLUSH.

Reset
REQ-036 RESET=0 SHALL immediately set state FETCH, PC=RESET_PC, pending target cleared, all outputs 0, IMEM_REQ=0, all BHT entries 2'b01.
REQ-037 RESET mid-WAIT SHALL abandon the outstanding request; a late IMEM_VALID SHALL not load outputs.

Verification
REQ-038 Reset release, 1-cycle memory returning 0 -> IMEM_ADDR sequence BFC00000, BFC00004, BFC00008; outputs Instr_PC_IF match, Plus4 = PC+4, valid pulses.
REQ-039 beq imm=0x0003 at 0x100, BHT entry 01 -> predicted not-taken, next fetch 0x104; after two BR_UPDATE taken, refetch -> Branch_prediction_OUT=1, fetches 0x104 then 0x110.
REQ-040 j 0x0000040 at 0xBFC00010 -> fetches BFC00014 then B0000100, Branch_prediction_OUT=1 on the jump.
REQ-041 STALL held 5 cycles after a response -> outputs frozen, no IMEM_REQ, resume fetch at PC+4 on release.
REQ-042 FLUSH with REDIRECT_PC=0x80000180 while WAIT, 3-cycle memory latency -> stale response dropped, next IMEM_ADDR 0x80000180, no valid output of stale data.
REQ-043 Four BR_UPDATE not-taken on one entry -> counter saturates at 0; four taken -> saturates at 3.
